// File: rtl/snowbro2_snd_bridge.sv
// Sound-CPU write bridge for the snowbro2 YM2151/OKI block. Writes are queued in a FIFO and
// replayed as registered CS/WE sequences; the YM busy window is counted in YM2151_CEN ticks.
module snowbro2_snd_bridge #(
  parameter int FIFO_AW = 3,
  parameter int YM_BUSY = 64,
  parameter int WE_HOLD = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       YM2151_CEN,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [2:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_wait,
  output logic       YM2151_CS,
  output logic       YM2151_WE,
  output logic       YM2151_WR_CMD,
  output logic [7:0] YM2151_DIN,
  input  logic [7:0] YM2151_DOUT,
  output logic       OKI_WE,
  output logic [7:0] OKI_DIN,
  input  logic [7:0] OKI_DOUT,
  output logic       OKI_BANK
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = $clog2(YM_BUSY + 2);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [BW-1:0]      BUSY_ONE = BW'(1);
  localparam logic [BW-1:0]      BUSY_LD  = BW'(YM_BUSY);
  localparam logic [3:0]         HOLD_LD  = 4'(WE_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, YM_WAIT} state_t;

  state_t state_q, state_d;
  logic [9:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d, ym_cnt_q, ym_cnt_d;
  logic               ovf_q, ovf_d;
  logic [BW-1:0]      busy_q, busy_d;
  logic [3:0]         hold_q, hold_d;
  logic [1:0]         tgt_q, tgt_d;
  logic [7:0]         dout_q, dout_d;
  logic               cs_q, cs_d, ym_we_q, ym_we_d, oki_we_q, oki_we_d;
  logic               a0_q, a0_d, bank_q, bank_d;
  logic [7:0]         ym_din_q, ym_din_d, oki_din_q, oki_din_d;

  logic [9:0] head;
  logic [1:0] head_tgt;
  logic       full, empty, wr_valid, push, pop, ovf_set, ym_pend;
  logic [3:0] cnt4;

  assign head     = mem_q[rd_ptr_q];
  assign head_tgt = head[9:8];
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign wr_valid = cpu_wr && !cpu_addr[2];
  // YM entries wait out the busy window at the head; OKI entries never do.
  assign pop      = (state_q == IDLE) && !empty && (head_tgt[1] || (busy_q == '0));
  assign push     = wr_valid && (!full || pop);
  assign ovf_set  = wr_valid && full && !pop;
  assign ym_pend  = (ym_cnt_q != '0) || (state_q == YM_WAIT) ||
                    ((state_q inside {SETUP, STROBE, RELEASE}) && !tgt_q[1]);
  assign cnt4     = 4'(count_q);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    ym_cnt_d = ym_cnt_q;
    if ((push && !cpu_addr[1]) && !(pop && !head_tgt[1]))      ym_cnt_d = ym_cnt_q + CNT_ONE;
    else if ((pop && !head_tgt[1]) && !(push && !cpu_addr[1])) ym_cnt_d = ym_cnt_q - CNT_ONE;
    ovf_d  = ovf_set || (ovf_q && !(cpu_rd && (cpu_addr == 3'd4)));
    dout_d = dout_q;
    if (cpu_rd) begin
      unique case (cpu_addr)
        3'd1:    dout_d = {YM2151_DOUT[7] | ym_pend, YM2151_DOUT[6:0]};
        3'd2:    dout_d = OKI_DOUT;
        3'd4:    dout_d = {ovf_q, 3'b000, cnt4};
        default: dout_d = 8'hFF;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = (YM2151_CEN && (busy_q != '0)) ? busy_q - BUSY_ONE : busy_q;
    hold_d    = hold_q;
    tgt_d     = tgt_q;
    cs_d      = cs_q;
    ym_we_d   = 1'b1;
    oki_we_d  = 1'b1;
    a0_d      = a0_q;
    ym_din_d  = ym_din_q;
    oki_din_d = oki_din_q;
    bank_d    = bank_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tgt_d = head_tgt;
          if (head_tgt == 2'd3) begin
            bank_d = head[0];
          end else begin
            state_d = SETUP;
            if (!head_tgt[1]) begin
              cs_d     = 1'b1;
              a0_d     = head_tgt[0];
              ym_din_d = head[7:0];
            end else begin
              oki_din_d = head[7:0];
            end
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        hold_d  = HOLD_LD;
        if (!tgt_q[1]) ym_we_d = 1'b0;
        else           oki_we_d = 1'b0;
      end
      STROBE: begin
        if (hold_q == '0) begin
          state_d = RELEASE;
        end else begin
          hold_d = hold_q - 4'd1;
          if (!tgt_q[1]) ym_we_d = 1'b0;
          else           oki_we_d = 1'b0;
        end
      end
      RELEASE: begin
        cs_d = 1'b0;
        if (tgt_q == 2'd1) begin
          busy_d  = BUSY_LD;
          state_d = YM_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      YM_WAIT: begin
        if (busy_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {cpu_addr[1:0], cpu_din};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ym_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= '0;
      hold_q    <= '0;
      tgt_q     <= '0;
      dout_q    <= 8'hFF;
      cs_q      <= 1'b0;
      ym_we_q   <= 1'b1;
      oki_we_q  <= 1'b1;
      a0_q      <= 1'b0;
      ym_din_q  <= '0;
      oki_din_q <= '0;
      bank_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ym_cnt_q  <= ym_cnt_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      tgt_q     <= tgt_d;
      dout_q    <= dout_d;
      cs_q      <= cs_d;
      ym_we_q   <= ym_we_d;
      oki_we_q  <= oki_we_d;
      a0_q      <= a0_d;
      ym_din_q  <= ym_din_d;
      oki_din_q <= oki_din_d;
      bank_q    <= bank_d;
    end
  end

  assign cpu_dout      = dout_q;
  assign cpu_wait      = full;
  assign YM2151_CS     = cs_q;
  assign YM2151_WE     = ym_we_q;
  assign YM2151_WR_CMD = a0_q;
  assign YM2151_DIN    = ym_din_q;
  assign OKI_WE        = oki_we_q;
  assign OKI_DIN       = oki_din_q;
  assign OKI_BANK      = bank_q;
endmodule

// File: tb/tb_snowbro2_snd_bridge.sv
// Scoreboard bench for snowbro2_snd_bridge: expected strobes and read data are queued by the
// stimulus and checked by a monitor on each WE falling edge / read response.
module tb_snowbro2_snd_bridge;
  localparam int WE_HOLD = 2;
  localparam int YM_BUSY = 64;

  logic       CLK = 1'b0, RESET = 1'b1, YM2151_CEN = 1'b0;
  logic       cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [2:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic [7:0] cpu_dout, YM2151_DIN, OKI_DIN;
  logic       cpu_wait, YM2151_CS, YM2151_WE, YM2151_WR_CMD, OKI_WE, OKI_BANK;
  logic [7:0] YM2151_DOUT = 8'h03;
  logic [7:0] OKI_DOUT = 8'h5A;

  snowbro2_snd_bridge #(.FIFO_AW(3), .YM_BUSY(YM_BUSY), .WE_HOLD(WE_HOLD)) dut (
    .CLK(CLK), .RESET(RESET), .YM2151_CEN(YM2151_CEN),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .YM2151_CS(YM2151_CS), .YM2151_WE(YM2151_WE), .YM2151_WR_CMD(YM2151_WR_CMD),
    .YM2151_DIN(YM2151_DIN), .YM2151_DOUT(YM2151_DOUT),
    .OKI_WE(OKI_WE), .OKI_DIN(OKI_DIN), .OKI_DOUT(OKI_DOUT), .OKI_BANK(OKI_BANK)
  );

  typedef struct packed {
    logic       oki;
    logic       a0;
    logic [7:0] d;
    logic       bank;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] rdq[$];
  int         n_cmp = 0, n_err = 0;
  int         ticks = 0;
  logic       rd_seen = 1'b0;
  logic       exp_bank = 1'b0;

  always #5 CLK = ~CLK;

  initial forever begin
    @(negedge CLK);
    YM2151_CEN = ~YM2151_CEN;
  end

  initial forever begin
    @(posedge CLK);
    if (YM2151_CEN) ticks++;
    rd_seen = cpu_rd && !RESET;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected strobe on each WE fall and the expected read after each cpu_rd.
  initial begin
    logic ym_p, oki_p, last_ymd, cur_ymd;
    int   lowcnt, tick_rise;
    exp_t e;
    logic [7:0] r;
    ym_p = 1'b1; oki_p = 1'b1; last_ymd = 1'b0; cur_ymd = 1'b0; lowcnt = 0; tick_rise = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        ym_p = 1'b1; oki_p = 1'b1; lowcnt = 0; last_ymd = 1'b0;
      end else begin
        if (rd_seen) begin
          n_cmp++;
          if (rdq.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected: got %0h expected no read", cpu_dout);
          end else begin
            r = rdq.pop_front();
            n_cmp--;
            chk("cpu_dout", {24'd0, cpu_dout}, {24'd0, r});
          end
        end
        if (!YM2151_WE || !OKI_WE) lowcnt++;
        if ((ym_p && !YM2151_WE) || (oki_p && !OKI_WE)) begin
          if (expq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL strobe_unexpected: got ym_we=%0b oki_we=%0b expected none", YM2151_WE, OKI_WE);
          end else begin
            e = expq.pop_front();
            chk("strobe_target", {31'd0, !OKI_WE}, {31'd0, e.oki});
            if (!e.oki) begin
              chk("ym_cs", {31'd0, YM2151_CS}, 32'd1);
              chk("ym_a0", {31'd0, YM2151_WR_CMD}, {31'd0, e.a0});
              chk("ym_din", {24'd0, YM2151_DIN}, {24'd0, e.d});
            end else begin
              chk("oki_din", {24'd0, OKI_DIN}, {24'd0, e.d});
              chk("oki_bank", {31'd0, OKI_BANK}, {31'd0, e.bank});
              chk("ym_cs_idle", {31'd0, YM2151_CS}, 32'd0);
            end
            if (last_ymd) chk("busy_gap_ok", {31'd0, (ticks - tick_rise) >= YM_BUSY}, 32'd1);
          end
          cur_ymd = !YM2151_WE && YM2151_WR_CMD;
        end
        if ((!ym_p && YM2151_WE) || (!oki_p && OKI_WE)) begin
          chk("we_low_cycles", lowcnt, WE_HOLD);
          lowcnt    = 0;
          last_ymd  = cur_ymd;
          tick_rise = ticks;
        end
        ym_p  = YM2151_WE;
        oki_p = OKI_WE;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK);
    cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
    if (a < 3'd3) expq.push_back('{oki: (a == 3'd2), a0: a[0], d: d, bank: exp_bank});
    else if (a == 3'd3) exp_bank = d[0];
    @(negedge CLK);
    cpu_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e);
    @(negedge CLK);
    cpu_rd = 1'b1; cpu_addr = a;
    rdq.push_back(e);
    @(negedge CLK);
    cpu_rd = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && expq.size() != 0; k++) @(negedge CLK);
    chk("drain_pending", expq.size(), 0);
    repeat (200) @(negedge CLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    chk("rst_ym_we", {31'd0, YM2151_WE}, 32'd1);
    chk("rst_oki_we", {31'd0, OKI_WE}, 32'd1);
    chk("rst_ym_cs", {31'd0, YM2151_CS}, 32'd0);
    chk("rst_bank", {31'd0, OKI_BANK}, 32'd0);
    chk("rst_dout", {24'd0, cpu_dout}, 32'hFF);
    chk("rst_wait", {31'd0, cpu_wait}, 32'd0);
    rd(3'd4, 8'h00);
    rd(3'd5, 8'hFF);
    rd(3'd1, 8'h03);
    rd(3'd2, 8'h5A);

    // YM address, data, then a second address gated by the busy window
    wr(3'd0, 8'h20);
    wr(3'd1, 8'hC0);
    wr(3'd0, 8'h28);
    rd(3'd1, 8'h83);
    repeat (20) @(negedge CLK);
    rd(3'd1, 8'h83);
    drain();
    rd(3'd1, 8'h03);

    // OKI write stays behind the YM busy window
    wr(3'd1, 8'h55);
    wr(3'd2, 8'h88);
    drain();

    // overflow while stalled in YM_WAIT
    wr(3'd1, 8'h31);
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      if (i == 7) chk("wait_at_7", {31'd0, cpu_wait}, 32'd0);
      if (i == 8) chk("wait_at_8", {31'd0, cpu_wait}, 32'd1);
      cpu_wr = 1'b1; cpu_addr = 3'd2; cpu_din = 8'hA0 + 8'(i);
      if (i < 8) expq.push_back('{oki: 1'b1, a0: 1'b0, d: 8'hA0 + 8'(i), bank: exp_bank});
    end
    @(negedge CLK);
    cpu_wr = 1'b0;
    chk("wait_full", {31'd0, cpu_wait}, 32'd1);
    rd(3'd4, 8'h88);
    rd(3'd4, 8'h08);
    drain();

    // bank switch ahead of an OKI strobe
    wr(3'd3, 8'h01);
    @(negedge CLK);
    chk("bank_after_pop", {31'd0, OKI_BANK}, 32'd1);
    wr(3'd2, 8'h10);
    drain();

    // reset during STROBE abandons the strobe and flushes the queue
    wr(3'd0, 8'h44);
    wr(3'd2, 8'h99);
    #1;
    RESET = 1'b1;
    expq.delete();
    exp_bank = 1'b0;
    @(negedge CLK);
    chk("rstmid_ym_we", {31'd0, YM2151_WE}, 32'd1);
    chk("rstmid_oki_we", {31'd0, OKI_WE}, 32'd1);
    chk("rstmid_ym_cs", {31'd0, YM2151_CS}, 32'd0);
    chk("rstmid_bank", {31'd0, OKI_BANK}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    rd(3'd4, 8'h00);
    repeat (300) @(negedge CLK);
    chk("final_expq", expq.size(), 0);
    chk("final_rdq", rdq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
